// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and parameter legality helpers for the
// decode-stage immediate generator.
package imm_pkg;

    localparam logic [2:0] IMM_I     = 3'b000;
    localparam logic [2:0] IMM_S     = 3'b001;
    localparam logic [2:0] IMM_B     = 3'b010;
    localparam logic [2:0] IMM_J     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_SHAMT = 3'b101;
    localparam logic [2:0] IMM_ZIMM  = 3'b110;
    localparam logic [2:0] IMM_RSVD  = 3'b111;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

    function automatic bit depth_legal(input int depth);
        return (depth >= 2) && (depth <= 8) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: Instr[31:7] + ImmSrc -> {illegal, imm}.
// All formats are built as a 32-bit value first, then extended to XLEN.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     Instr,
    input  logic [2:0]      ImmSrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // Re-index so bit numbers match the architectural instruction word.
    logic [31:7] iw;
    logic [31:0] raw;
    logic        sext;

    assign iw = Instr;

    always_comb begin
        raw     = '0;
        sext    = 1'b1;
        illegal = 1'b0;
        case (ImmSrc)
            IMM_I: raw = {{20{iw[31]}}, iw[31:20]};
            IMM_S: raw = {{20{iw[31]}}, iw[31:25], iw[11:7]};
            IMM_B: raw = {{19{iw[31]}}, iw[31], iw[7], iw[30:25], iw[11:8], 1'b0};
            IMM_J: raw = {{11{iw[31]}}, iw[31], iw[19:12], iw[20], iw[30:21], 1'b0};
            IMM_U: raw = {iw[31:12], 12'b0};
            IMM_SHAMT: begin
                sext = 1'b0;
                raw  = (XLEN == 64) ? {26'b0, iw[25:20]} : {27'b0, iw[24:20]};
            end
            IMM_ZIMM: begin
                sext = 1'b0;
                raw  = {27'b0, iw[19:15]};
            end
            default: begin
                sext    = 1'b0;
                illegal = 1'b1;
            end
        endcase
    end

    if (XLEN > 32) begin : g_wide
        assign imm = {{(XLEN-32){sext & raw[31]}}, raw};
    end else begin : g_narrow
        assign imm = raw;
    end

endmodule

// File: rtl/imm_ext_pipe.sv
// Buffered immediate generator: decodes the immediate and queues it with its
// illegal flag in a DEPTH-entry FIFO between decode and execute.
module imm_ext_pipe
    import imm_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [24:0]     Instr,
    input  logic [2:0]      ImmSrc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ImmExt,
    output logic            imm_illegal
);

    if (!xlen_legal(XLEN) || !depth_legal(DEPTH)) begin : g_bad_param
        $error("imm_ext_pipe: illegal XLEN or DEPTH");
    end

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [XLEN-1:0]  dec_imm;
    logic             dec_illegal;
    logic [XLEN:0]    mem [DEPTH];
    logic [XLEN:0]    head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             push;
    logic             pop;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .Instr   (Instr),
        .ImmSrc  (ImmSrc),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Handshake: a transfer happens on any edge where valid and ready are both
    // high; valid must hold with stable payload until accepted, and ready is
    // a function of registered occupancy only (no combinational path through).
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {dec_illegal, dec_imm};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Gate the head so an empty FIFO never exposes stale storage.
    assign head        = mem[rd_ptr];
    assign ImmExt      = out_valid ? head[XLEN-1:0] : '0;
    assign imm_illegal = out_valid & head[XLEN];

endmodule
